// File: rtl/alu_pkg.sv
// Shared types for the iterative execute-stage ALU: operation codes,
// FSM states and small helpers that classify operations.
package alu_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        ADD   = 4'd0,
        SUB   = 4'd1,
        SLT   = 4'd2,
        SLTU  = 4'd3,
        AND   = 4'd4,
        OR    = 4'd5,
        XOR   = 4'd6,
        NOR   = 4'd7,
        SLL   = 4'd8,
        SRL   = 4'd9,
        SRA   = 4'd10,
        LUI   = 4'd11,
        MULT  = 4'd12,
        MULTU = 4'd13,
        DIV   = 4'd14,
        DIVU  = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    // Operations that go through the iterative multiply/divide engine.
    function automatic logic is_multi(input alu_op_e op);
        return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
    endfunction

    // Divide flavours run the restoring-subtract step instead of shift-add.
    function automatic logic is_div(input alu_op_e op);
        return (op == DIV) || (op == DIVU);
    endfunction

    // Signed multiply/divide need operand magnitudes and a final sign fix.
    function automatic logic is_signed_md(input alu_op_e op);
        return (op == MULT) || (op == DIV);
    endfunction

endpackage

// File: rtl/alu_muldiv_step.sv
// One radix-2 iteration of the multiply/divide engine on the {acc,quo}
// register pair. Multiply: conditional add of the multiplicand into acc,
// then shift the pair right. Divide: shift the pair left, trial-subtract
// the divisor from acc and shift the quotient bit into quo.
// A single adder serves both flavours.
module alu_muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            isDiv_i,
    input  logic [XLEN-1:0] acc_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] operand_i,
    output logic [XLEN-1:0] acc_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] addA;
    logic [XLEN+1:0] addB;
    logic            carryIn;
    logic [XLEN+1:0] sum;

    // Shared adder: acc+multiplicand for multiply, (acc<<1|msb)-divisor for divide.
    always_comb begin
        shifted = {acc_i, quo_i[XLEN-1]};
        if (isDiv_i) begin
            addA    = {1'b0, shifted};
            addB    = ~{2'b00, operand_i};
            carryIn = 1'b1;
        end else begin
            addA    = {2'b00, acc_i};
            addB    = quo_i[0] ? {2'b00, operand_i} : '0;
            carryIn = 1'b0;
        end
        sum = addA + addB + {{(XLEN+1){1'b0}}, carryIn};
    end

    // Commit the step: restore on borrow for divide, shift right for multiply.
    always_comb begin
        if (isDiv_i) begin
            if (!sum[XLEN+1]) begin
                acc_o = sum[XLEN-1:0];
                quo_o = {quo_i[XLEN-2:0], 1'b1};
            end else begin
                acc_o = shifted[XLEN-1:0];
                quo_o = {quo_i[XLEN-2:0], 1'b0};
            end
        end else begin
            {acc_o, quo_o} = {sum[XLEN:0], quo_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/alu_iter.sv
// Execute-stage ALU with valid/ready handshakes on both sides and a
// registered result. Simple integer ops finish in one cycle; multiply and
// divide iterate one bit per cycle on operand magnitudes and are
// sign-corrected on the last step. A flush drops whatever is in flight.
// Optional feature: define ALU_OVF_EN to report signed overflow of ADD/SUB
// on the ovf port; without it ovf is tied low.
module alu_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] result_hi,
    output logic            ovf
);

    localparam int SH_W = $clog2(XLEN);

    alu_state_e      state_q, state_d;
    logic [SH_W-1:0] cnt_q, cnt_d;
    alu_op_e         opReg_q, opReg_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] opnd_q, opnd_d;
    logic            negQuo_q, negQuo_d;
    logic            negRem_q, negRem_d;
    logic            divZero_q, divZero_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [XLEN-1:0] resultHi_q, resultHi_d;

    alu_op_e         opIn;
    logic            inReady;
    logic            accept;
    logic            aNeg, bNeg;
    logic [XLEN-1:0] aMag, bMag;
    logic [XLEN-1:0] sum, diff;
    logic [SH_W-1:0] shamt;
    logic [XLEN-1:0] simpleRes;
    logic            mdIsDiv;
    logic [XLEN-1:0] stepAcc, stepQuo;
    logic [2*XLEN-1:0] prod, prodFix;
    logic [XLEN-1:0] quoFix, remFix;

    assign opIn = alu_op_e'(op);

    // Ready when idle or when the held result leaves this cycle; flush blocks it.
    always_comb begin
        inReady = !flush && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
        accept  = in_valid && inReady;
    end

    // Reduce signed operands to magnitudes so the engine only sees unsigned values.
    always_comb begin
        aNeg = is_signed_md(opIn) && src1[XLEN-1];
        bNeg = is_signed_md(opIn) && src2[XLEN-1];
        aMag = aNeg ? -src1 : src1;
        bMag = bNeg ? -src2 : src2;
    end

    // Single-cycle operations; anything not listed computes ADD.
    always_comb begin
        sum       = src1 + src2;
        diff      = src1 - src2;
        shamt     = src1[SH_W-1:0];
        simpleRes = sum;
        case (opIn)
            SUB:     simpleRes = diff;
            SLT:     simpleRes = {{(XLEN-1){1'b0}}, ($signed(src1) < $signed(src2))};
            SLTU:    simpleRes = {{(XLEN-1){1'b0}}, (src1 < src2)};
            AND:     simpleRes = src1 & src2;
            OR:      simpleRes = src1 | src2;
            XOR:     simpleRes = src1 ^ src2;
            NOR:     simpleRes = ~(src1 | src2);
            SLL:     simpleRes = src2 << shamt;
            SRL:     simpleRes = src2 >> shamt;
            SRA:     simpleRes = $signed(src2) >>> shamt;
            LUI:     simpleRes = {src2[15:0], {(XLEN-16){1'b0}}};
            default: simpleRes = sum;
        endcase
    end

    assign mdIsDiv = is_div(opReg_q);

    alu_muldiv_step #(
        .XLEN(XLEN)
    ) u_step (
        .isDiv_i   (mdIsDiv),
        .acc_i     (acc_q),
        .quo_i     (quo_q),
        .operand_i (opnd_q),
        .acc_o     (stepAcc),
        .quo_o     (stepQuo)
    );

    // Sign correction of the final step; divide by zero forces an all-ones quotient.
    always_comb begin
        prod    = {stepAcc, stepQuo};
        prodFix = negQuo_q ? -prod : prod;
        quoFix  = divZero_q ? '1 : (negQuo_q ? -stepQuo : stepQuo);
        remFix  = negRem_q ? -stepAcc : stepAcc;
    end

    // Next-state logic: iterate in BUSY, hold in DONE, load on accept, flush wins.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        opReg_d    = opReg_q;
        acc_d      = acc_q;
        quo_d      = quo_q;
        opnd_d     = opnd_q;
        negQuo_d   = negQuo_q;
        negRem_d   = negRem_q;
        divZero_d  = divZero_q;
        result_d   = result_q;
        resultHi_d = resultHi_q;

        case (state_q)
            BUSY: begin
                acc_d = stepAcc;
                quo_d = stepQuo;
                cnt_d = cnt_q - SH_W'(1);
                if (cnt_q == '0) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    if (mdIsDiv) begin
                        result_d   = quoFix;
                        resultHi_d = remFix;
                    end else begin
                        result_d   = prodFix[XLEN-1:0];
                        resultHi_d = prodFix[2*XLEN-1:XLEN];
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
            end
        endcase

        if (accept) begin
            opReg_d = opIn;
            if (is_multi(opIn)) begin
                state_d   = BUSY;
                cnt_d     = SH_W'(XLEN-1);
                acc_d     = '0;
                quo_d     = aMag;
                opnd_d    = bMag;
                negQuo_d  = aNeg ^ bNeg;
                negRem_d  = aNeg;
                divZero_d = (src2 == '0);
            end else begin
                state_d    = DONE;
                result_d   = simpleRes;
                resultHi_d = '0;
            end
        end

        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    // State, engine and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            opReg_q    <= ADD;
            acc_q      <= '0;
            quo_q      <= '0;
            opnd_q     <= '0;
            negQuo_q   <= 1'b0;
            negRem_q   <= 1'b0;
            divZero_q  <= 1'b0;
            result_q   <= '0;
            resultHi_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            opReg_q    <= opReg_d;
            acc_q      <= acc_d;
            quo_q      <= quo_d;
            opnd_q     <= opnd_d;
            negQuo_q   <= negQuo_d;
            negRem_q   <= negRem_d;
            divZero_q  <= divZero_d;
            result_q   <= result_d;
            resultHi_q <= resultHi_d;
        end
    end

`ifdef ALU_OVF_EN
    logic ovf_q, ovf_d;
    logic addOvf, subOvf;

    // Signed overflow is captured with the ADD/SUB result; every other op clears it.
    always_comb begin
        addOvf = (src1[XLEN-1] == src2[XLEN-1]) && (sum[XLEN-1] != src1[XLEN-1]);
        subOvf = (src1[XLEN-1] != src2[XLEN-1]) && (diff[XLEN-1] != src1[XLEN-1]);
        ovf_d  = ovf_q;
        if (accept) begin
            ovf_d = ((opIn == ADD) && addOvf) || ((opIn == SUB) && subOvf);
        end
    end

    // Overflow flag register, held alongside the result.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign in_ready  = inReady;
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign result_hi = resultHi_q;

endmodule

// File: tb/tb_alu_iter.sv
// Scoreboard bench for alu_iter (XLEN=32): the driver pushes expected results
// computed by a plain-arithmetic reference model, a separate monitor pops and
// compares whenever a result is handed over. Honours ALU_OVF_EN for ovf.
module tb_alu_iter;
    import alu_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic [31:0] hi;
        logic        ovf;
        logic [3:0]  op;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = 4'd0;
    logic [31:0] src1 = 32'd0;
    logic [31:0] src2 = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic [31:0] result_hi;
    logic        ovf;

    exp_t sbq[$];
    int   testsRun = 0;
    int   testsFailed = 0;
    int   popCount = 0;
    logic bpRandom = 1'b0;
    logic bpForce = 1'b1;

    alu_iter #(.XLEN(32)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src1      (src1),
        .src2      (src2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Consumer back-pressure, updated shortly after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            out_ready = bpRandom ? ($urandom_range(0, 3) != 0) : bpForce;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached, %0d tests run", testsRun);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference model straight from the operation definitions.
    function automatic exp_t model(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa, sb, ua, ub, wide;
        logic signed [31:0] bs;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        bs = b;
        e.op = opc;
        e.hi = 32'd0;
        e.ovf = 1'b0;
        e.res = a + b;
        case (opc)
            SUB:   e.res = a - b;
            SLT:   e.res = (sa < sb) ? 32'd1 : 32'd0;
            SLTU:  e.res = (ua < ub) ? 32'd1 : 32'd0;
            AND:   e.res = a & b;
            OR:    e.res = a | b;
            XOR:   e.res = a ^ b;
            NOR:   e.res = ~(a | b);
            SLL:   e.res = b << a[4:0];
            SRL:   e.res = b >> a[4:0];
            SRA:   e.res = bs >>> a[4:0];
            LUI:   e.res = {b[15:0], 16'h0000};
            MULT: begin
                wide = sa * sb;
                {e.hi, e.res} = wide;
            end
            MULTU: begin
                wide = ua * ub;
                {e.hi, e.res} = wide;
            end
            DIV: begin
                if (b == 32'd0) begin
                    e.res = 32'hFFFF_FFFF;
                    e.hi  = a;
                end else begin
                    wide  = sa / sb;
                    e.res = wide[31:0];
                    wide  = sa % sb;
                    e.hi  = wide[31:0];
                end
            end
            DIVU: begin
                if (b == 32'd0) begin
                    e.res = 32'hFFFF_FFFF;
                    e.hi  = a;
                end else begin
                    e.res = a / b;
                    e.hi  = a % b;
                end
            end
            default: e.res = a + b;
        endcase
`ifdef ALU_OVF_EN
        if (opc == ADD) begin
            wide = sa + sb;
            e.ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
        end else if (opc == SUB) begin
            wide = sa - sb;
            e.ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
        end
`endif
        return e;
    endfunction

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    // Present an op (called just after a rising edge) and hold it until accepted.
    task automatic applyStimulus(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b,
                                 output int waited);
        logic accepted;
        in_valid = 1'b1;
        op = opc;
        src1 = a;
        src2 = b;
        waited = 0;
        accepted = 1'b0;
        while (!accepted && waited < 300) begin
            @(negedge clk);
            if (in_ready) accepted = 1'b1;
            else waited++;
        end
        if (accepted) sbq.push_back(model(opc, a, b));
        else checkOutput("accept timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Count cycles from the accept edge until out_valid, then let the result go.
    task automatic waitLatency(input int expLat, input string name);
        int k;
        k = 0;
        while (k < 100) begin
            @(negedge clk);
            k++;
            if (out_valid) break;
        end
        checkOutput(name, 64'(k), 64'(expLat));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sbq.size() != 0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (sbq.size() != 0) checkOutput("drain timeout", 64'(sbq.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every handed-over result is compared with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resetn && out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    checkOutput("unexpected out_valid", 64'd1, 64'd0);
                end else begin
                    e = sbq.pop_front();
                    checkOutput($sformatf("result op=%0d", e.op), 64'(result), 64'(e.res));
                    checkOutput($sformatf("result_hi op=%0d", e.op), 64'(result_hi), 64'(e.hi));
                    checkOutput($sformatf("ovf op=%0d", e.op), 64'(ovf), 64'(e.ovf));
                    popCount++;
                end
            end
        end
    end

    localparam int NDIR = 13;
    logic [3:0]  dirOp [NDIR] = '{ADD, SUB, MULT, MULTU, DIVU, DIV, DIV, DIV,
                                   SRA, SLTU, SLT, LUI, SLL};
    logic [31:0] dirA  [NDIR] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFD, 32'hFFFF_FFFD,
                                   32'd7, 32'h8000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                                   32'd31, 32'd1, 32'd1, 32'd0, 32'd4};
    logic [31:0] dirB  [NDIR] = '{32'h1, 32'h1, 32'h5, 32'h5,
                                   32'd0, 32'hFFFF_FFFF, 32'd2, 32'd0,
                                   32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0001_ABCD, 32'h1};

    initial begin
        int   w;
        int   p;
        logic [31:0] hold;
        logic seen;

        // Reset state while resetn is held low.
        #2;
        checkOutput("reset out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset result", 64'(result), 64'd0);
        checkOutput("reset result_hi", 64'(result_hi), 64'd0);
        checkOutput("reset ovf", 64'(ovf), 64'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        checkOutput("reset in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Directed corner cases with latency check.
        for (int i = 0; i < NDIR; i++) begin
            applyStimulus(dirOp[i], dirA[i], dirB[i], w);
            in_valid = 1'b0;
            waitLatency((dirOp[i] >= MULT) ? 33 : 1, $sformatf("latency op=%0d", dirOp[i]));
        end
        drain();

        // Back-pressure: result must hold and in_ready stay low.
        bpForce = 1'b0;
        applyStimulus(ADD, $urandom, $urandom, w);
        in_valid = 1'b0;
        hold = result;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp result hold", 64'(result), 64'(hold));
            checkOutput("bp out_valid", 64'(out_valid), 64'd1);
            checkOutput("bp in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        bpForce = 1'b1;
        p = popCount;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(4'($urandom_range(0, 11)), $urandom, $urandom, w);
            checkOutput("b2b accept wait", 64'(w), 64'd0);
        end
        in_valid = 1'b0;
        checkOutput("b2b results per cycle", 64'(popCount - p), 64'd8);
        drain();

        // Randomised traffic with random back-pressure.
        bpRandom = 1'b1;
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            applyStimulus(4'($urandom_range(0, 15)), pickOperand(), pickOperand(), w);
        end
        in_valid = 1'b0;
        drain();
        bpRandom = 1'b0;
        bpForce = 1'b1;
        @(posedge clk);
        #1;

        // Flush in the middle of a divide.
        applyStimulus(DIV, pickOperand(), pickOperand(), w);
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        if (sbq.size() > 0) sbq.delete(sbq.size() - 1);
        @(negedge clk);
        checkOutput("flush in_ready", 64'(in_ready), 64'd0);
        checkOutput("flush busy out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        checkOutput("flush idle in_ready", 64'(in_ready), 64'd1);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checkOutput("flush no result", 64'(seen), 64'd0);
        @(posedge clk);
        #1;

        // Flush takes priority over a simultaneous in_valid.
        in_valid = 1'b1;
        op = ADD;
        src1 = 32'd1;
        src2 = 32'd2;
        flush = 1'b1;
        @(negedge clk);
        checkOutput("flush beats in_valid ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("flush beats in_valid out", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a multiply.
        applyStimulus(MULT, 32'hFFFF_FFFD, 32'h5, w);
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        sbq.delete();
        checkOutput("midreset out_valid", 64'(out_valid), 64'd0);
        checkOutput("midreset result", 64'(result), 64'd0);
        checkOutput("midreset result_hi", 64'(result_hi), 64'd0);
        checkOutput("midreset ovf", 64'(ovf), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        checkOutput("midreset in_ready", 64'(in_ready), 64'd1);
        checkOutput("midreset idle", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
